// File: rtl/spi_image_sender_if.sv
// Byte-stream handshake between an image byte source and the SPI sender.
// The source drives data/valid/last; the sender answers with ready.
`timescale 1ns/1ps
interface spi_image_sender_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/spi_image_sender.sv
// SPI mode-0 initiator that streams bytes MSB-first under one chip-select
// frame per image. A byte flagged last closes the frame; cs_n then stays
// high for at least CS_IDLE cycles before the next frame can start.
`timescale 1ns/1ps
module spi_image_sender #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_image_sender_if.slave     tx,
    output logic                  byte_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  SCLK,
    output logic                  COPI,
    output logic                  spi_cs_n
);

    // One counter serves every timed state, so it must hold the longest duration.
    localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_END  = CNT_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LO,
        S_HI,
        S_NEXT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       r_shreg;
    logic [7:0]       w_shreg_next;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       w_bit_cnt_next;
    logic             r_last;
    logic             w_last_next;
    logic             r_sclk;
    logic             r_copi;
    logic             r_cs_n;
    logic             r_byte_done;
    logic             r_frame_done;
    logic             w_byte_done_next;
    logic             w_frame_done_next;
    logic             w_sclk_next;
    logic             w_cs_n_next;
    logic             w_ready;
    logic             w_hs;

    // Ready depends only on state (and reset), never on the source's valid.
    always_comb begin
        w_ready     = ((r_state == S_IDLE) || (r_state == S_NEXT)) && !rst;
        w_hs        = w_ready && tx.tx_valid;
        tx.tx_ready = w_ready;
    end

    // Next-state, datapath and pulse decode for the frame sequencer.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_shreg_next      = r_shreg;
        w_bit_cnt_next    = r_bit_cnt;
        w_last_next       = r_last;
        w_byte_done_next  = 1'b0;
        w_frame_done_next = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_hs) begin
                    w_shreg_next   = tx.tx_data;
                    w_last_next    = tx.tx_last;
                    w_bit_cnt_next = 4'd0;
                    w_state_next   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_END) begin
                    w_cnt_next   = '0;
                    w_state_next = S_LO;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_LO: begin
                if (r_cnt == DIV_END) begin
                    w_cnt_next   = '0;
                    w_state_next = S_HI;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_HI: begin
                if (r_cnt == DIV_END) begin
                    // Shifting here changes COPI on the same edge SCLK falls,
                    // so data is stable across the whole next high phase.
                    w_cnt_next     = '0;
                    w_shreg_next   = {r_shreg[6:0], 1'b0};
                    w_bit_cnt_next = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_byte_done_next = 1'b1;
                        w_state_next     = r_last ? S_HOLD : S_NEXT;
                    end else begin
                        w_state_next = S_LO;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_NEXT: begin
                // Holds CS low with SCLK low for at least one cycle, longer
                // while the source has nothing to offer.
                w_cnt_next = '0;
                if (w_hs) begin
                    w_shreg_next   = tx.tx_data;
                    w_last_next    = tx.tx_last;
                    w_bit_cnt_next = 4'd0;
                    w_state_next   = S_LO;
                end
            end
            S_HOLD: begin
                if (r_cnt == HOLD_END) begin
                    w_cnt_next   = '0;
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == IDLE_END) begin
                    w_cnt_next        = '0;
                    w_frame_done_next = 1'b1;
                    w_state_next      = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Pin levels follow the state being entered, so they line up with it exactly.
    always_comb begin
        w_sclk_next = (w_state_next == S_HI);
        w_cs_n_next = (w_state_next == S_IDLE) || (w_state_next == S_GAP);
    end

    // State, datapath and registered pin drivers; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shreg      <= 8'h00;
            r_bit_cnt    <= 4'd0;
            r_last       <= 1'b0;
            r_sclk       <= 1'b0;
            r_copi       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_byte_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_shreg      <= w_shreg_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_last       <= w_last_next;
            r_sclk       <= w_sclk_next;
            r_copi       <= w_shreg_next[7];
            r_cs_n       <= w_cs_n_next;
            r_byte_done  <= w_byte_done_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign SCLK       = r_sclk;
    assign COPI       = r_copi;
    assign spi_cs_n   = r_cs_n;
    assign byte_done  = r_byte_done;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_image_sender.sv
// Directed bench for spi_image_sender: instance A (CLK_DIV=2, CS_SETUP=1,
// CS_HOLD=1, CS_IDLE=2) and instance B (CLK_DIV=1) share clock and reset.
`timescale 1ns/1ps
module tb_spi_image_sender;

    logic clk;
    logic rst;

    spi_image_sender_if a_if ();
    spi_image_sender_if b_if ();

    logic a_bd, a_fd, a_busy, a_sclk, a_copi, a_cs_n;
    logic b_bd, b_fd, b_busy, b_sclk, b_copi, b_cs_n;

    spi_image_sender #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .tx         (a_if.slave),
        .byte_done  (a_bd),
        .frame_done (a_fd),
        .busy       (a_busy),
        .SCLK       (a_sclk),
        .COPI       (a_copi),
        .spi_cs_n   (a_cs_n)
    );

    spi_image_sender #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .tx         (b_if.slave),
        .byte_done  (b_bd),
        .frame_done (b_fd),
        .busy       (b_busy),
        .SCLK       (b_sclk),
        .COPI       (b_copi),
        .spi_cs_n   (b_cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Monitor counters only ever increase; tests work on differences.
    int          a_rises = 0, a_cs_low = 0, a_cs_falls = 0, a_bdn = 0, a_fdn = 0, a_both = 0;
    int          a_cyc = 0, a_cs_rise_cyc = 0, a_fd_cyc = 0;
    logic [15:0] a_bits = 16'h0;
    logic        a_prev_sclk = 1'b0, a_prev_cs = 1'b1;
    int          b_rises = 0, b_cs_low = 0, b_hi = 0, b_bdn = 0, b_fdn = 0;
    logic [15:0] b_bits = 16'h0;
    logic        b_prev_sclk = 1'b0;

    // Sample instance A mid-cycle, away from the active edge.
    always @(negedge clk) begin
        a_cyc = a_cyc + 1;
        if (a_sclk && !a_prev_sclk) begin
            a_rises = a_rises + 1;
            a_bits  = {a_bits[14:0], a_copi};
        end
        if (!a_cs_n) a_cs_low = a_cs_low + 1;
        if (!a_cs_n && a_prev_cs) a_cs_falls = a_cs_falls + 1;
        if (a_cs_n && !a_prev_cs) a_cs_rise_cyc = a_cyc;
        if (a_bd) a_bdn = a_bdn + 1;
        if (a_fd) begin
            a_fdn    = a_fdn + 1;
            a_fd_cyc = a_cyc;
        end
        if (a_bd && a_fd) a_both = a_both + 1;
        a_prev_sclk = a_sclk;
        a_prev_cs   = a_cs_n;
    end

    // Sample instance B mid-cycle.
    always @(negedge clk) begin
        if (b_sclk && !b_prev_sclk) begin
            b_rises = b_rises + 1;
            b_bits  = {b_bits[14:0], b_copi};
        end
        if (!b_cs_n) b_cs_low = b_cs_low + 1;
        if (b_sclk) b_hi = b_hi + 1;
        if (b_bd) b_bdn = b_bdn + 1;
        if (b_fd) b_fdn = b_fdn + 1;
        b_prev_sclk = b_sclk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer one byte and hold it until the handshake edge has passed.
    task automatic push(input int sel, input logic [7:0] d, input logic l);
        int n;
        n = 0;
        if (sel == 0) begin
            a_if.tx_data = d; a_if.tx_last = l; a_if.tx_valid = 1'b1;
        end else begin
            b_if.tx_data = d; b_if.tx_last = l; b_if.tx_valid = 1'b1;
        end
        while ((((sel == 0) ? a_if.tx_ready : b_if.tx_ready) == 1'b0) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check_eq("push_timeout", n, 0);
        @(posedge clk);
        #1;
        a_if.tx_valid = 1'b0;
        b_if.tx_valid = 1'b0;
    endtask

    task automatic wait_frame(input int sel);
        int base;
        int n;
        base = (sel == 0) ? a_fdn : b_fdn;
        n = 0;
        while ((((sel == 0) ? a_fdn : b_fdn) == base) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check_eq("frame_timeout", n, 0);
        tick();
        tick();
    endtask

    int r0, c0, f0, bd0, fd0, n, stall_bad;

    initial begin
        rst = 1'b1;
        a_if.tx_data = 8'h00; a_if.tx_valid = 1'b0; a_if.tx_last = 1'b0;
        b_if.tx_data = 8'h00; b_if.tx_valid = 1'b0; b_if.tx_last = 1'b0;
        repeat (3) tick();
        check_eq("ready_in_reset", a_if.tx_ready, 0);
        rst = 1'b0;
        tick();
        check_eq("rst_sclk",  a_sclk, 0);
        check_eq("rst_copi",  a_copi, 0);
        check_eq("rst_cs_n",  a_cs_n, 1);
        check_eq("rst_busy",  a_busy, 0);
        check_eq("rst_bd_fd", {a_bd, a_fd}, 0);
        check_eq("rst_ready", a_if.tx_ready, 1);

        // Single byte 0xA5: 1 + 8*4 + 1 = 34 cycles of cs_n low.
        r0 = a_rises; c0 = a_cs_low; f0 = a_cs_falls; bd0 = a_bdn; fd0 = a_fdn;
        push(0, 8'hA5, 1'b1);
        check_eq("a5_busy", a_busy, 1);
        wait_frame(0);
        check_eq("a5_rises",  a_rises - r0, 8);
        check_eq("a5_bits",   a_bits[7:0], 8'hA5);
        check_eq("a5_cs_low", a_cs_low - c0, 34);
        check_eq("a5_window", a_cs_falls - f0, 1);
        check_eq("a5_bd",     a_bdn - bd0, 1);
        check_eq("a5_fd",     a_fdn - fd0, 1);
        check_eq("a5_fd_gap", a_fd_cyc - a_cs_rise_cyc, 2);
        check_eq("a5_idle",   a_busy, 0);
        $display("frame 0xA5: cs_low=%0d rises=%0d", a_cs_low - c0, a_rises - r0);

        // Two bytes back-to-back: one NEXT cycle between them, 34+32+1 = 67.
        r0 = a_rises; c0 = a_cs_low; f0 = a_cs_falls; bd0 = a_bdn; fd0 = a_fdn;
        push(0, 8'h3C, 1'b0);
        push(0, 8'hC3, 1'b1);
        wait_frame(0);
        check_eq("b2b_rises",  a_rises - r0, 16);
        check_eq("b2b_bits",   a_bits, 16'h3CC3);
        check_eq("b2b_cs_low", a_cs_low - c0, 67);
        check_eq("b2b_window", a_cs_falls - f0, 1);
        check_eq("b2b_bd",     a_bdn - bd0, 2);
        check_eq("b2b_fd",     a_fdn - fd0, 1);
        $display("frame 0x3C,0xC3: cs_low=%0d rises=%0d", a_cs_low - c0, a_rises - r0);

        // Stall of 10 extra NEXT cycles grows the window by exactly 10.
        r0 = a_rises; c0 = a_cs_low; f0 = a_cs_falls; bd0 = a_bdn;
        stall_bad = 0;
        push(0, 8'h5A, 1'b0);
        n = 0;
        while (!a_if.tx_ready && n < 500) begin tick(); n++; end
        if (n >= 500) check_eq("stall_timeout", n, 0);
        repeat (10) begin
            if (a_if.tx_ready !== 1'b1 || a_sclk !== 1'b0 || a_cs_n !== 1'b0) stall_bad++;
            tick();
        end
        check_eq("stall_hold", stall_bad, 0);
        push(0, 8'h81, 1'b1);
        wait_frame(0);
        check_eq("stall_cs_low", a_cs_low - c0, 77);
        check_eq("stall_window", a_cs_falls - f0, 1);
        check_eq("stall_bits",   a_bits, 16'h5A81);
        check_eq("stall_bd",     a_bdn - bd0, 2);
        $display("frame 0x5A,0x81 stalled: cs_low=%0d", a_cs_low - c0);

        // Reset during the 5th high phase of 0xFF.
        r0 = a_rises; bd0 = a_bdn; fd0 = a_fdn;
        push(0, 8'hFF, 1'b1);
        n = 0;
        while ((a_rises - r0) < 5 && n < 500) begin tick(); n++; end
        check_eq("rst_in_hi", a_sclk, 1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_cs_n",  a_cs_n, 1);
        check_eq("mid_rst_sclk",  a_sclk, 0);
        check_eq("mid_rst_copi",  a_copi, 0);
        check_eq("mid_rst_busy",  a_busy, 0);
        check_eq("mid_rst_ready", a_if.tx_ready, 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", a_if.tx_ready, 1);
        repeat (5) tick();
        check_eq("mid_rst_no_bd", a_bdn - bd0, 0);
        check_eq("mid_rst_no_fd", a_fdn - fd0, 0);
        $display("frame 0xFF aborted by reset after %0d rises", a_rises - r0);

        // CLK_DIV=1 corner on instance B: 1 + 16 + 1 = 18 cycles low.
        r0 = b_rises; c0 = b_cs_low; n = b_hi; bd0 = b_bdn;
        push(1, 8'h01, 1'b1);
        wait_frame(1);
        check_eq("div1_rises",  b_rises - r0, 8);
        check_eq("div1_hi",     b_hi - n, 8);
        check_eq("div1_bits",   b_bits[7:0], 8'h01);
        check_eq("div1_cs_low", b_cs_low - c0, 18);
        check_eq("div1_bd",     b_bdn - bd0, 1);
        $display("frame 0x01 div1: cs_low=%0d rises=%0d", b_cs_low - c0, b_rises - r0);

        check_eq("bd_fd_overlap", a_both, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
